// File: rtl/instr_fetch_ctrl_pkg.sv
// rtl/instr_fetch_ctrl_pkg.sv - shared types and constants for the instruction fetch controller
package instr_fetch_ctrl_pkg;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// rtl/instr_fetch_ctrl_if.sv - control, memory and decode-side signals of the fetch controller
interface instr_fetch_ctrl_if;
  import instr_fetch_ctrl_pkg::*;

  logic              start;
  logic              stop;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rd;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              busy;

  modport master (
    output start, stop, redir_valid, redir_pc, imem_rd, out_ready,
    input  imem_addr, out_valid, out_instr, out_pc, busy
  );

  modport slave (
    input  start, stop, redir_valid, redir_pc, imem_rd, out_ready,
    output imem_addr, out_valid, out_instr, out_pc, busy
  );

endinterface

// File: rtl/instr_fetch_ctrl_fifo.sv
// rtl/instr_fetch_ctrl_fifo.sv - small fetch buffer with flush and registered head entry
module instr_fetch_ctrl_fifo
  import instr_fetch_ctrl_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     wr_entry,
  output logic [CNT_W-1:0] count,
  output logic             head_valid,
  output fetch_entry_t     head
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_next;

  // occupancy after this cycle's push/pop
  always_comb begin
    count_next = count + CNT_W'(push) - CNT_W'(pop);
  end

  // storage array; no reset needed since the head register masks stale slots
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // pointers, count and the registered head (next entry, or bypassed write when it becomes head)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head       <= '0;
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count      <= count_next;
      head_valid <= (count_next != '0);
      if (push && ((count == '0) || (pop && count == CNT_W'(1)))) begin
        head <= wr_entry;
      end else if (pop && count >= CNT_W'(2)) begin
        head <= mem[rd_ptr + 1'b1];
      end
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - PC sequencing, start/stop FSM and redirect handling for instruction fetch
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  instr_fetch_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t      state;
  logic              busy_q;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  count;
  logic              head_valid;
  fetch_entry_t      head;
  fetch_entry_t      wr_entry;
  logic              push;
  logic              pop;

  // a full buffer may still take a new word when the head leaves in the same cycle
  always_comb begin
    pop      = head_valid & bus.out_ready;
    push     = (state == FETCH) & ~bus.redir_valid & ((count < CNT_W'(DEPTH)) | pop);
    wr_entry = '{pc: pc, instr: bus.imem_rd};
  end

  // FSM with registered busy; pc follows redirect first, then sequential fetch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      pc     <= RESET_PC;
    end else begin
      if (bus.redir_valid) begin
        pc <= bus.redir_pc & ~ADDR_W'(3);
      end else if (push) begin
        pc <= pc + ADDR_W'(PC_STEP);
      end
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= FETCH;
            busy_q <= 1'b1;
          end
        end
        FETCH: begin
          if (bus.stop) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (count == '0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  instr_fetch_ctrl_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .pop        (pop),
    .flush      (bus.redir_valid),
    .wr_entry   (wr_entry),
    .count      (count),
    .head_valid (head_valid),
    .head       (head)
  );

  assign bus.imem_addr = pc;
  assign bus.out_valid = head_valid;
  assign bus.out_instr = head.instr;
  assign bus.out_pc    = head.pc;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb/tb_instr_fetch_ctrl.sv - randomized and directed bench for instr_fetch_ctrl against a queue model
module tb_instr_fetch_ctrl;

  localparam int DEPTH = 2;

  logic clk;
  logic reset_n;
  logic [31:0] imem [64];

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: mode 0 idle, 1 fetching, 2 draining
  int          m_mode;
  logic [7:0]  m_pc;
  logic [7:0]  m_qpc [$];
  logic [31:0] m_qins [$];
  logic [7:0]  pops [$];

  instr_fetch_ctrl_if bus ();

  instr_fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign bus.imem_rd = imem[bus.imem_addr[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = 8'h00;
    m_qpc.delete();
    m_qins.delete();
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(bus.out_valid), 32'(m_qpc.size() != 0));
    check("busy", 32'(bus.busy), 32'(m_mode != 0));
    check("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
    if (m_qpc.size() != 0) begin
      check("out_pc", 32'(bus.out_pc), 32'(m_qpc[0]));
      check("out_instr", bus.out_instr, m_qins[0]);
    end
  endtask

  // one clock: check settled outputs, drive inputs, advance model, step to next negedge
  task automatic cyc(input logic st, input logic sp, input logic rv, input logic [7:0] rp, input logic rdy);
    logic pop_m;
    logic push_m;
    int   sz;
    check_outputs();
    bus.start       = st;
    bus.stop        = sp;
    bus.redir_valid = rv;
    bus.redir_pc    = rp;
    bus.out_ready   = rdy;
    if (bus.out_valid && rdy) pops.push_back(bus.out_pc);
    sz     = m_qpc.size();
    pop_m  = (sz > 0) && rdy;
    push_m = (m_mode == 1) && !rv && ((sz < DEPTH) || pop_m);
    if (pop_m) begin
      void'(m_qpc.pop_front());
      void'(m_qins.pop_front());
    end
    if (rv) begin
      m_qpc.delete();
      m_qins.delete();
      m_pc = rp & 8'hFC;
    end else if (push_m) begin
      m_qpc.push_back(m_pc);
      m_qins.push_back(imem[m_pc[7:2]]);
      m_pc = m_pc + 8'd4;
    end
    case (m_mode)
      0: if (st) m_mode = 1;
      1: if (sp) m_mode = 2;
      default: if (sz == 0) m_mode = 0;
    endcase
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, rdy);
  endtask

  task automatic do_reset();
    reset_n         = 1'b0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.redir_valid = 1'b0;
    bus.redir_pc    = 8'h00;
    bus.out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    check("rst_out_instr", bus.out_instr, 32'd0);
    check("rst_out_pc", 32'(bus.out_pc), 32'd0);
    reset_n = 1'b1;
    model_reset();
    pops.delete();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = $urandom;
    imem[0] = 32'hE5312004;
    imem[1] = 32'hE5312004;
    imem[2] = 32'hE5312004;

    // streaming from reset, decode always ready
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    idle_cycles(5, 1'b1);
    check("stream_n", 32'(pops.size() >= 3), 32'd1);
    if (pops.size() >= 3) begin
      check("stream_pc0", 32'(pops[0]), 32'h00);
      check("stream_pc1", 32'(pops[1]), 32'h04);
      check("stream_pc2", 32'(pops[2]), 32'h08);
    end

    // backpressure fills the buffer, then release
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    idle_cycles(5, 1'b0);
    check("bp_addr_hold", 32'(bus.imem_addr), 32'h08);
    idle_cycles(4, 1'b1);
    check("bp_n", 32'(pops.size() >= 3), 32'd1);
    if (pops.size() >= 3) begin
      check("bp_pc0", 32'(pops[0]), 32'h00);
      check("bp_pc1", 32'(pops[1]), 32'h04);
      check("bp_pc2", 32'(pops[2]), 32'h08);
    end

    // redirect while full, target low bits dropped
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    idle_cycles(3, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 8'h43, 1'b0);
    check("redir_flush", 32'(bus.out_valid), 32'd0);
    pops.delete();
    idle_cycles(3, 1'b1);
    check("redir_first", 32'(pops.size() >= 1 ? pops[0] : 8'hFF), 32'h40);

    // pc wrap from top of memory
    cyc(1'b0, 1'b0, 1'b1, 8'hF8, 1'b1);
    pops.delete();
    idle_cycles(6, 1'b1);
    check("wrap_n", 32'(pops.size() >= 4), 32'd1);
    if (pops.size() >= 4) begin
      check("wrap_0", 32'(pops[0]), 32'hF8);
      check("wrap_1", 32'(pops[1]), 32'hFC);
      check("wrap_2", 32'(pops[2]), 32'h00);
      check("wrap_3", 32'(pops[3]), 32'h04);
    end

    // stop with a full buffer, drain, then resume from frozen pc
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    idle_cycles(3, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    idle_cycles(5, 1'b1);
    check("stop_idle", 32'(bus.busy), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    idle_cycles(4, 1'b1);

    // redirect together with stop, and with start from idle
    cyc(1'b0, 1'b1, 1'b1, 8'h20, 1'b1);
    idle_cycles(3, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 8'h31, 1'b1);
    idle_cycles(4, 1'b1);

    // asynchronous reset mid-fetch with full buffer
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    idle_cycles(4, 1'b0);
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_imem_addr", 32'(bus.imem_addr), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    do_reset();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 15) == 0, 8'($urandom), $urandom_range(0, 3) != 0);
    end
    check_outputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
